// File: rtl/enc_rr_arbiter_pkg.sv
// Shared types and helpers for the registered priority / round-robin encoder.
package enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int unsigned MAX_N = 64;

  // Index width that never collapses to zero bits, even for tiny N.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (idx < n) v = MAX_N'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/enc_rr_arbiter_if.sv
// Request/result bus between request sources, the arbiter and a stalling consumer.
interface enc_rr_arbiter_if
  import enc_pkg::*;
#(
  parameter int unsigned N = 4
);
  localparam int unsigned W = clog2_safe(N);

  logic [N-1:0] req;
  logic         mode;
  logic         out_ready;
  logic [W-1:0] idx;
  logic [N-1:0] grant;
  logic         valid;
  logic [W-1:0] ptr;

  modport master (output req, mode, out_ready, input idx, grant, valid, ptr);
  modport slave  (input req, mode, out_ready, output idx, grant, valid, ptr);
endinterface

// File: rtl/enc_rr_arbiter_pick.sv
// Combinational winner search: highest-set-bit fixed priority, or first set bit
// at/after ptr found by scanning a doubled request vector masked from ptr upward.
module enc_pick
  import enc_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = clog2_safe(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  input  logic         i_mode,
  output logic         o_any,
  output logic [W-1:0] o_win_idx
);

  localparam logic [2*N-1:0] LOW_ONES = {{N{1'b0}}, {N{1'b1}}};

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_masked;
  int unsigned    w_rr_pos;
  int unsigned    w_rr_idx;
  int unsigned    w_fp_idx;

  // Window [ptr, ptr+N-1] of the doubled vector covers every source exactly once.
  assign w_dbl    = {i_req, i_req};
  assign w_masked = w_dbl & (LOW_ONES << i_ptr);

  always_comb begin
    w_rr_pos = 0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (w_masked[j]) w_rr_pos = j;
    end
    w_rr_idx = (w_rr_pos >= N) ? (w_rr_pos - N) : w_rr_pos;
  end

  always_comb begin
    w_fp_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) w_fp_idx = i;
    end
  end

  assign o_any     = |i_req;
  assign o_win_idx = i_mode ? W'(w_rr_idx) : W'(w_fp_idx);

endmodule

// File: rtl/enc_rr_arbiter.sv
// Registered N-input encoder/arbiter holding each winner under valid/ready.
//   state | meaning
//   IDLE  | no result held, valid=0, waiting for any request
//   HOLD  | result held in idx/grant, valid=1, frozen until out_ready
module enc_rr_arbiter
  import enc_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input logic             clk,
  input logic             rst_n,
  enc_rr_arbiter_if.slave bus
);

  localparam int unsigned  W    = clog2_safe(N);
  localparam logic [W-1:0] LAST = W'(N-1);

  state_e       r_state,     w_state_nxt;
  logic [W-1:0] r_idx,       w_idx_nxt;
  logic [N-1:0] r_grant,     w_grant_nxt;
  logic         r_valid,     w_valid_nxt;
  logic [W-1:0] r_ptr,       w_ptr_nxt;
  logic         r_mode_held, w_mode_held_nxt;

  logic         w_hs;
  logic [W-1:0] w_ptr_inc;
  logic [W-1:0] w_ptr_arb;
  logic         w_any;
  logic [W-1:0] w_win_idx;

  assign w_hs      = r_valid & bus.out_ready;
  assign w_ptr_inc = (r_idx == LAST) ? '0 : r_idx + 1'b1;
  // Back-to-back round-robin loads must already see the advanced pointer.
  assign w_ptr_arb = (w_hs && r_mode_held) ? w_ptr_inc : r_ptr;

  enc_pick #(.N(N)) u_pick (
    .i_req     (bus.req),
    .i_ptr     (w_ptr_arb),
    .i_mode    (bus.mode),
    .o_any     (w_any),
    .o_win_idx (w_win_idx)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_grant_nxt     = r_grant;
    w_valid_nxt     = r_valid;
    w_ptr_nxt       = r_ptr;
    w_mode_held_nxt = r_mode_held;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt     = HOLD;
          w_idx_nxt       = w_win_idx;
          w_grant_nxt     = N'(onehot(32'(w_win_idx), N));
          w_valid_nxt     = 1'b1;
          w_mode_held_nxt = bus.mode;
        end
      end
      HOLD: begin
        if (w_hs) begin
          w_ptr_nxt = w_ptr_arb;
          if (w_any) begin
            w_idx_nxt       = w_win_idx;
            w_grant_nxt     = N'(onehot(32'(w_win_idx), N));
            w_mode_held_nxt = bus.mode;
          end else begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
            w_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_grant     <= '0;
      r_valid     <= 1'b0;
      r_ptr       <= '0;
      r_mode_held <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_grant     <= w_grant_nxt;
      r_valid     <= w_valid_nxt;
      r_ptr       <= w_ptr_nxt;
      r_mode_held <= w_mode_held_nxt;
    end
  end

  assign bus.idx   = r_idx;
  assign bus.grant = r_grant;
  assign bus.valid = r_valid;
  assign bus.ptr   = r_ptr;

endmodule

// File: tb/tb_enc_rr_arbiter.sv
// Scoreboard bench for enc_rr_arbiter: N=4 and N=5 instances against a behavioural model.
module tb_enc_rr_arbiter;
  import enc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  enc_rr_arbiter_if #(.N(4)) if4();
  enc_rr_arbiter_if #(.N(5)) if5();

  enc_rr_arbiter #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  enc_rr_arbiter #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    logic        valid;
    int          idx;
    logic [63:0] grant;
    int          ptr;
  } exp_t;

  exp_t sb[$];

  int   nn[2] = '{4, 5};
  logic m_valid[2];
  int   m_idx[2];
  int   m_ptr[2];
  logic m_held[2];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int ref_pick(input logic [63:0] r, input int n, input int p, input logic md);
    if (!md) begin
      for (int i = n-1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 0; k < n; k++) if (r[(p+k)%n]) return (p+k)%n;
    end
    return 0;
  endfunction

  task automatic model_step(input int d, input logic [63:0] r, input logic md, input logic rdy);
    exp_t e;
    logic any;
    any = (r != 0);
    if (!m_valid[d]) begin
      if (any) begin
        m_idx[d] = ref_pick(r, nn[d], m_ptr[d], md); m_valid[d] = 1'b1; m_held[d] = md;
      end
    end else if (rdy) begin
      if (m_held[d]) m_ptr[d] = (m_idx[d] + 1) % nn[d];
      if (any) begin
        m_idx[d] = ref_pick(r, nn[d], m_ptr[d], md); m_held[d] = md;
      end else begin
        m_valid[d] = 1'b0;
      end
    end
    e.dut   = d;
    e.valid = m_valid[d];
    e.idx   = m_idx[d];
    e.grant = m_valid[d] ? (64'd1 << m_idx[d]) : 64'd0;
    e.ptr   = m_ptr[d];
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] r4, input logic [4:0] r5, input logic md,
                      input logic rdy, input string tag);
    exp_t e;
    if4.req = r4; if4.mode = md; if4.out_ready = rdy;
    if5.req = r5; if5.mode = md; if5.out_ready = rdy;
    model_step(0, 64'(r4), md, rdy);
    model_step(1, 64'(r5), md, rdy);
    @(posedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        chk({tag, "_n4_valid"}, 64'(if4.valid), 64'(e.valid));
        chk({tag, "_n4_grant"}, 64'(if4.grant), e.grant);
        chk({tag, "_n4_ptr"},   64'(if4.ptr),   64'(e.ptr));
        if (e.valid) chk({tag, "_n4_idx"}, 64'(if4.idx), 64'(e.idx));
      end else begin
        chk({tag, "_n5_valid"}, 64'(if5.valid), 64'(e.valid));
        chk({tag, "_n5_grant"}, 64'(if5.grant), e.grant);
        chk({tag, "_n5_ptr"},   64'(if5.ptr),   64'(e.ptr));
        if (e.valid) chk({tag, "_n5_idx"}, 64'(if5.idx), 64'(e.idx));
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_idx[d] = 0; m_ptr[d] = 0; m_held[d] = 1'b0;
    end
    sb.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_n4_valid"}, 64'(if4.valid), 64'd0);
    chk({tag, "_n4_grant"}, 64'(if4.grant), 64'd0);
    chk({tag, "_n4_idx"},   64'(if4.idx),   64'd0);
    chk({tag, "_n4_ptr"},   64'(if4.ptr),   64'd0);
    chk({tag, "_n5_valid"}, 64'(if5.valid), 64'd0);
    chk({tag, "_n5_ptr"},   64'(if5.ptr),   64'd0);
  endtask

  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0;
    if4.req = '0; if4.mode = 1'b0; if4.out_ready = 1'b0;
    if5.req = '0; if5.mode = 1'b0; if5.out_ready = 1'b0;
    model_reset();
    #12;
    chk_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // fixed priority, always ready
    step(4'b0110, 5'b0, 1'b0, 1'b1, "fx_a");
    chk("fx_idx2", 64'(if4.idx), 64'd2);
    chk("fx_grant", 64'(if4.grant), 64'b0100);
    step(4'b1001, 5'b0, 1'b0, 1'b1, "fx_b");
    chk("fx_idx3", 64'(if4.idx), 64'd3);
    step(4'b0000, 5'b0, 1'b0, 1'b1, "fx_end");
    chk("fx_ptr0", 64'(if4.ptr), 64'd0);

    // stall: result frozen while req and mode move underneath
    step(4'b0010, 5'b0, 1'b0, 1'b0, "stall0");
    step(4'b1000, 5'b0, 1'b0, 1'b0, "stall1");
    step(4'b1000, 5'b0, 1'b1, 1'b0, "stall2");
    step(4'b0000, 5'b0, 1'b0, 1'b0, "stall3");
    step(4'b1000, 5'b0, 1'b0, 1'b0, "stall4");
    chk("stall_idx1", 64'(if4.idx), 64'd1);
    chk("stall_valid", 64'(if4.valid), 64'd1);
    step(4'b1000, 5'b0, 1'b0, 1'b1, "stall_hs");
    chk("stall_next_idx3", 64'(if4.idx), 64'd3);
    step(4'b0000, 5'b0, 1'b0, 1'b1, "b2b_end");
    chk("b2b_end_valid", 64'(if4.valid), 64'd0);
    step(4'b0000, 5'b0, 1'b0, 1'b1, "idle");

    // round-robin fairness on N=4
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 5'b0, 1'b1, 1'b1, "rr");
      chk("rr_seq", 64'(if4.idx), 64'(rr_exp[k]));
    end
    step(4'b0000, 5'b0, 1'b1, 1'b1, "rr_end");
    chk("rr_ptr_after", 64'(if4.ptr), 64'd1);

    // wrap and sparse on N=5
    step(4'b0, 5'b01000, 1'b1, 1'b1, "wrap0");
    step(4'b0, 5'b00101, 1'b1, 1'b1, "wrap1");
    chk("wrap_idx0", 64'(if5.idx), 64'd0);
    chk("wrap_ptr4", 64'(if5.ptr), 64'd4);
    step(4'b0, 5'b00101, 1'b1, 1'b1, "wrap2");
    chk("wrap_idx2", 64'(if5.idx), 64'd2);
    chk("wrap_ptr1", 64'(if5.ptr), 64'd1);
    step(4'b0, 5'b00000, 1'b1, 1'b1, "wrap3");
    chk("wrap_ptr3", 64'(if5.ptr), 64'd3);

    // random traffic
    for (int k = 0; k < 200; k++) begin
      step(4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), "rand");
    end

    // asynchronous reset while holding a result
    step(4'b1111, 5'b11111, 1'b1, 1'b0, "pre_rst");
    chk("pre_rst_valid", 64'(if4.valid), 64'd1);
    if4.req = '0; if5.req = '0;
    rst_n = 1'b0;
    #2;
    chk_zero("async_rst");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(4'b0000, 5'b0, 1'b0, 1'b1, "post_rst");
    chk("post_rst_valid", 64'(if4.valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/enc_rr_arbiter.md
Name: enc_rr_arbiter

Overview:
- Registered, parametrised successor to the team's 4-to-2 priority encoder (Q1..Q0 + v).
- Takes N request lines and encodes one winner into an index plus a one-hot grant, with a valid output.
- Selectable mode: fixed priority (highest index wins, same convention as the 4x2 encoder) or round-robin.
- Holds each result under a valid/ready handshake; sits between request sources and a downstream consumer that can stall.

Parameters:
- N, 4, number of request lines; legal range 2..64, need not be a power of two.
- W, max(1,clog2(N)), index width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N  request vector; bit i = source i requesting
- mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin
- out_ready  in  1  consumer accepts the current result this cycle
- idx  out  W  encoded index of the granted source
- grant  out  N  one-hot copy of idx; all zero when valid=0
- valid  out  1  idx/grant hold a result (successor of v)
- ptr  out  W  current round-robin start pointer (debug/observability)

Behaviour:
- Reset (rst_n low, asynchronous): idx=0, grant=0, valid=0, ptr=0, state=IDLE. Takes effect immediately, including mid-handshake; any held result is discarded.
- State machine, two states:
  - IDLE: if |req, register the winner; valid=1 at the next edge (latency 1 cycle from req to valid); go to HOLD. If req=0, stay in IDLE with valid=0.
  - HOLD: idx/grant/valid are frozen while out_ready=0, even if req changes or the granted bit drops. Once latched, a grant is never withdrawn.
  - HOLD, handshake (valid & out_ready at the edge): the result is consumed. In the same edge, re-arbitrate on the current req. If |req, load the new winner, valid stays 1, remain in HOLD (back-to-back, one result per cycle). If req=0, clear valid and grant and go to IDLE.
- Fixed mode: winner = highest set bit of req.
- Round-robin mode: search upward from ptr (ptr, ptr+1, ..., N-1, 0, ..., ptr-1) and take the first set bit.
- ptr update: changes only on handshake of a round-robin-mode result; new ptr = (accepted idx + 1) mod N, with N-1 wrapping to 0. Fixed-mode results leave ptr unchanged.
- mode is sampled at the arbitration edge. Changing mode while in HOLD does not alter the held result.
- Simultaneous events: reset dominates all. A handshake and a new req in the same cycle produce the back-to-back load described above.
- Non-power-of-two N: idx never exceeds N-1; ptr arithmetic is mod N, not mod 2^W.

Decomposition:
- Package enc_pkg:
  - state enum {IDLE, HOLD};
  - constant function for safe clog2 (returns at least 1);
  - function onehot(idx, N).
- Sub-module enc_pick: purely combinational.
  - Inputs: req, ptr, mode.
  - Outputs: any, win_idx.
  - Implements fixed-priority search and the rotated round-robin search via a double-width masked priority scan.
- The top-level module holds the state register, output registers, ptr and the handshake logic.

Test Plan:
- Reset/idle: assert rst_n=0 mid-HOLD with valid=1 -> valid, grant, idx and ptr go to 0 immediately. With req=0 after release -> valid stays 0.
- Fixed priority (N=4, mode=0, out_ready=1): req=4'b0110 -> next cycle idx=2, grant=4'b0100, valid=1. req=4'b1001 -> idx=3. ptr stays 0 throughout.
- Stall hold: req=4'b0010, out_ready=0 for 5 cycles, then req changes to 4'b1000 -> idx=1 and valid=1 held all 5 cycles. After out_ready=1 -> one handshake, then idx=3 the following cycle.
- Round-robin fairness (N=4, mode=1, req=4'b1111, out_ready=1) -> idx sequence 0,1,2,3,0 on consecutive cycles; ptr sequence 1,2,3,0,1.
- Wrap and sparse: N=5, mode=1, ptr=4, req=5'b00101 -> idx=0, then ptr=1. Next winner is idx=2, then ptr=3.
- Back-to-back end: single req bit held for one accepted cycle, then req=0 -> valid drops to 0 the cycle after the handshake and the state returns to IDLE.
